// File: rtl/exe_mem_reg.sv
// exe_mem_reg: EXE/MEM pipeline register with a two-state data-memory handshake.
// Define EXE_MEM_PERF_EN to add the saturating stall_cnt output.
module exe_mem_reg #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXE_valid,
    input  logic [XLEN-1:0]   EXE_alu_out,
    input  logic [XLEN-1:0]   EXE_rs2_data,
    input  logic [4:0]        EXE_rd_addr,
    input  logic              EXE_reg_write,
    input  logic              EXE_mem_read,
    input  logic              EXE_mem_write,
    input  logic [2:0]        EXE_funct3,
    input  logic              flush,
    output logic              MEM_valid,
    output logic [XLEN-1:0]   MEM_alu_out,
    output logic [XLEN-1:0]   MEM_rs2_data,
    output logic [4:0]        MEM_rd_addr,
    output logic              MEM_reg_write,
    output logic [2:0]        MEM_funct3,
    output logic              EXE_MEM_fwd_write,
    output logic [XLEN-1:0]   EXE_MEM_fwd_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [XLEN-1:0]   dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic              dm_ack,
    output logic              mem_busy
`ifdef EXE_MEM_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic mem_access(input logic valid, input logic kill,
                                        input logic rd, input logic wr);
        return valid & ~kill & (rd | wr);
    endfunction

    function automatic logic fwd_source(input logic live, input logic we,
                                        input logic [4:0] rd, input logic is_load);
        return live & we & (rd != 5'd0) & ~is_load;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              busy_s;
    logic              capture_s;
    logic              live_s;
    logic              start_s;

    logic              valid_r;
    logic [XLEN-1:0]   alu_out_r;
    logic [XLEN-1:0]   rs2_data_r;
    logic [4:0]        rd_addr_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [2:0]        funct3_r;

    // Stall decision and next state; busy depends only on state and dm_ack
    always_comb begin
        busy_s      = 1'b0;
        state_nxt_s = state_r;
        live_s      = EXE_valid & ~flush;
        start_s     = mem_access(EXE_valid, flush, EXE_mem_read, EXE_mem_write);
        case (state_r)
            IDLE: begin
                busy_s      = 1'b0;
                state_nxt_s = start_s ? REQ : IDLE;
            end
            REQ: begin
                busy_s = ~dm_ack;
                if (dm_ack) begin
                    state_nxt_s = start_s ? REQ : IDLE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            default: begin
                busy_s      = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
        capture_s = ~busy_s;
    end

    // Handshake state; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pipeline fields: load when not stalled, otherwise hold the older instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r     <= 1'b0;
            alu_out_r   <= {XLEN{1'b0}};
            rs2_data_r  <= {XLEN{1'b0}};
            rd_addr_r   <= 5'd0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            funct3_r    <= 3'd0;
        end else if (capture_s) begin
            valid_r     <= live_s;
            alu_out_r   <= EXE_alu_out;
            rs2_data_r  <= EXE_rs2_data;
            rd_addr_r   <= EXE_rd_addr;
            reg_write_r <= EXE_reg_write & live_s;
            mem_read_r  <= EXE_mem_read & live_s;
            mem_write_r <= EXE_mem_write & live_s;
            funct3_r    <= EXE_funct3;
        end else begin
            valid_r     <= valid_r;
            alu_out_r   <= alu_out_r;
            rs2_data_r  <= rs2_data_r;
            rd_addr_r   <= rd_addr_r;
            reg_write_r <= reg_write_r;
            mem_read_r  <= mem_read_r;
            mem_write_r <= mem_write_r;
            funct3_r    <= funct3_r;
        end
    end

    assign MEM_valid         = valid_r;
    assign MEM_alu_out       = alu_out_r;
    assign MEM_rs2_data      = rs2_data_r;
    assign MEM_rd_addr       = rd_addr_r;
    assign MEM_reg_write     = reg_write_r;
    assign MEM_funct3        = funct3_r;
    // Loads are not a forwarding source here; their data only exists after the access
    assign EXE_MEM_fwd_write = fwd_source(valid_r, reg_write_r, rd_addr_r, mem_read_r);
    assign EXE_MEM_fwd_data  = alu_out_r;
    assign dm_req            = (state_r == REQ);
    assign dm_we             = (state_r == REQ) & mem_write_r;
    assign dm_addr           = alu_out_r;
    assign dm_wdata          = rs2_data_r;
    assign mem_busy          = busy_s;

`ifdef EXE_MEM_PERF_EN
    logic [PERF_W-1:0] stall_cnt_r;

    // Count stalled cycles, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {PERF_W{1'b0}};
        end else if (busy_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    // PERF_W only shapes the counter; nothing to build without it
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Bench for exe_mem_reg: directed vector table, then random traffic vs a transaction-level model.
module tb_exe_mem_reg;
    localparam int XLEN   = 32;
    localparam int PERF_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              EXE_valid;
    logic [XLEN-1:0]   EXE_alu_out;
    logic [XLEN-1:0]   EXE_rs2_data;
    logic [4:0]        EXE_rd_addr;
    logic              EXE_reg_write;
    logic              EXE_mem_read;
    logic              EXE_mem_write;
    logic [2:0]        EXE_funct3;
    logic              flush;
    logic              MEM_valid;
    logic [XLEN-1:0]   MEM_alu_out;
    logic [XLEN-1:0]   MEM_rs2_data;
    logic [4:0]        MEM_rd_addr;
    logic              MEM_reg_write;
    logic [2:0]        MEM_funct3;
    logic              EXE_MEM_fwd_write;
    logic [XLEN-1:0]   EXE_MEM_fwd_data;
    logic              dm_req;
    logic              dm_we;
    logic [XLEN-1:0]   dm_addr;
    logic [XLEN-1:0]   dm_wdata;
    logic              dm_ack;
    logic              mem_busy;
`ifdef EXE_MEM_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
`endif

    exe_mem_reg #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .EXE_valid(EXE_valid), .EXE_alu_out(EXE_alu_out), .EXE_rs2_data(EXE_rs2_data),
        .EXE_rd_addr(EXE_rd_addr), .EXE_reg_write(EXE_reg_write), .EXE_mem_read(EXE_mem_read),
        .EXE_mem_write(EXE_mem_write), .EXE_funct3(EXE_funct3), .flush(flush),
        .MEM_valid(MEM_valid), .MEM_alu_out(MEM_alu_out), .MEM_rs2_data(MEM_rs2_data),
        .MEM_rd_addr(MEM_rd_addr), .MEM_reg_write(MEM_reg_write), .MEM_funct3(MEM_funct3),
        .EXE_MEM_fwd_write(EXE_MEM_fwd_write), .EXE_MEM_fwd_data(EXE_MEM_fwd_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .mem_busy(mem_busy)
`ifdef EXE_MEM_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic rst, valid;
        logic [31:0] alu, rs2;
        logic [4:0] rd;
        logic rw, mr, mw, flush, ack, chk;
        logic e_valid, e_rw;
        logic [4:0] e_rd;
        logic e_fwd, e_req, e_we, e_busy;
        logic [31:0] e_alu, e_wd;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic valid, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw, input logic fl, input logic ack,
                                input logic chk, input logic ev, input logic erw,
                                input logic [4:0] erd, input logic efwd, input logic ereq,
                                input logic ewe, input logic ebusy, input logic [31:0] ealu,
                                input logic [31:0] ewd);
        vec_t v;
        v.rst = rst; v.valid = valid; v.alu = alu; v.rs2 = rs2; v.rd = rd; v.rw = rw;
        v.mr = mr; v.mw = mw; v.flush = fl; v.ack = ack; v.chk = chk;
        v.e_valid = ev; v.e_rw = erw; v.e_rd = erd; v.e_fwd = efwd; v.e_req = ereq;
        v.e_we = ewe; v.e_busy = ebusy; v.e_alu = ealu; v.e_wd = ewd;
        return v;
    endfunction

    // Transaction-level reference: one slot for the instruction in MEM, plus "access outstanding"
    typedef struct packed {
        logic valid;
        logic [31:0] alu, rs2;
        logic [4:0] rd;
        logic rw, ld, st;
        logic [2:0] f3;
    } slot_t;

    slot_t       m;
    bit          waiting;
    longint      stalls;
    bit          model_ok = 1'b0;
    localparam longint STALL_MAX = (64'd1 << PERF_W) - 64'd1;

    task automatic model_check(input int cyc);
        string p;
        p = $sformatf("c%0d.", cyc);
        check({p, "MEM_valid"}, MEM_valid, m.valid);
        check({p, "MEM_alu_out"}, MEM_alu_out, m.alu);
        check({p, "MEM_rs2_data"}, MEM_rs2_data, m.rs2);
        check({p, "MEM_rd_addr"}, MEM_rd_addr, m.rd);
        check({p, "MEM_reg_write"}, MEM_reg_write, m.valid && m.rw);
        check({p, "MEM_funct3"}, MEM_funct3, m.f3);
        check({p, "fwd_write"}, EXE_MEM_fwd_write, m.valid && m.rw && (m.rd != 5'd0) && !m.ld);
        check({p, "fwd_data"}, EXE_MEM_fwd_data, m.alu);
        check({p, "dm_req"}, dm_req, waiting);
        check({p, "dm_we"}, dm_we, waiting && m.st);
        check({p, "dm_addr"}, dm_addr, m.alu);
        check({p, "dm_wdata"}, dm_wdata, m.rs2);
        check({p, "mem_busy"}, mem_busy, waiting && !dm_ack);
`ifdef EXE_MEM_PERF_EN
        check({p, "stall_cnt"}, 32'(stall_cnt), 32'(stalls));
`endif
    endtask

    task automatic model_edge();
        if (rst) begin
            m = '0; waiting = 1'b0; stalls = 0;
        end else if (waiting && !dm_ack) begin
            if (stalls < STALL_MAX) stalls++;
        end else begin
            m.valid = EXE_valid && !flush;
            m.alu = EXE_alu_out; m.rs2 = EXE_rs2_data; m.rd = EXE_rd_addr;
            m.rw = EXE_reg_write; m.ld = EXE_mem_read; m.st = EXE_mem_write; m.f3 = EXE_funct3;
            waiting = m.valid && (m.ld || m.st);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; EXE_valid = v.valid; EXE_alu_out = v.alu; EXE_rs2_data = v.rs2;
        EXE_rd_addr = v.rd; EXE_reg_write = v.rw; EXE_mem_read = v.mr; EXE_mem_write = v.mw;
        EXE_funct3 = 3'd0; flush = v.flush; dm_ack = v.ack;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        if (rst) model_ok = 1'b1;
        #1;
    endtask

    vec_t tbl[28];

    initial begin
        // Row: inputs (rst valid alu rs2 rd rw mr mw flush ack chk) | expected before the edge
        tbl[0]  = mk(1,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[2]  = mk(0,1,32'h1234,0,5,1,0,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0,0,0,0,0,1,  1,1,5,1,0,0,0,32'h1234,0);
        tbl[4]  = mk(0,1,32'h1234,0,5,1,0,0,1,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,0,0,0,1,  0,0,5,0,0,0,0,32'h1234,0);
        tbl[6]  = mk(0,1,32'h55,0,0,1,0,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[7]  = mk(0,0,0,0,0,0,0,0,0,0,1,  1,1,0,0,0,0,0,32'h55,0);
        tbl[8]  = mk(0,1,32'h100,0,7,1,1,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[9]  = mk(0,1,32'hABC,0,9,1,0,0,0,0,1,  1,1,7,0,1,0,1,32'h100,0);
        tbl[10] = mk(0,1,32'hABC,0,9,1,0,0,0,0,1,  1,1,7,0,1,0,1,32'h100,0);
        tbl[11] = mk(0,1,32'hABC,0,9,1,0,0,0,1,1,  1,1,7,0,1,0,0,32'h100,0);
        tbl[12] = mk(0,0,0,0,0,0,0,0,0,0,1,  1,1,9,1,0,0,0,32'hABC,0);
        tbl[13] = mk(0,1,32'h200,32'hDEAD,0,0,0,1,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[14] = mk(0,1,32'h204,32'hBEEF,0,0,0,1,0,0,1,  1,0,0,0,1,1,1,32'h200,32'hDEAD);
        tbl[15] = mk(0,1,32'h204,32'hBEEF,0,0,0,1,0,1,1,  1,0,0,0,1,1,0,32'h200,32'hDEAD);
        tbl[16] = mk(0,0,0,0,0,0,0,0,0,0,1,  1,0,0,0,1,1,1,32'h204,32'hBEEF);
        tbl[17] = mk(0,0,0,0,0,0,0,0,0,1,1,  1,0,0,0,1,1,0,32'h204,32'hBEEF);
        tbl[18] = mk(0,0,0,0,0,0,0,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[19] = mk(0,1,32'h300,0,3,1,1,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[20] = mk(0,0,0,0,0,0,0,0,0,0,1,  1,1,3,0,1,0,1,32'h300,0);
        tbl[21] = mk(1,0,0,0,0,0,0,0,0,0,1,  1,1,3,0,1,0,1,32'h300,0);
        tbl[22] = mk(0,0,0,0,0,0,0,0,0,1,1,  0,0,0,0,0,0,0,0,0);
        tbl[23] = mk(0,0,0,0,0,0,0,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[24] = mk(0,1,32'h400,0,4,1,1,0,0,0,1,  0,0,0,0,0,0,0,0,0);
        tbl[25] = mk(0,1,32'h600,0,6,1,0,0,1,0,1,  1,1,4,0,1,0,1,32'h400,0);
        tbl[26] = mk(0,1,32'h600,0,6,1,0,0,1,1,1,  1,1,4,0,1,0,0,32'h400,0);
        tbl[27] = mk(0,0,0,0,0,0,0,0,0,0,1,  0,0,6,0,0,0,0,32'h600,0);

        m = '0; waiting = 1'b0; stalls = 0;
        apply(tbl[0]);
        @(posedge clk); #1;

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i]);
            #1;
            if (tbl[i].chk) begin
                check($sformatf("v%0d.MEM_valid", i), MEM_valid, tbl[i].e_valid);
                check($sformatf("v%0d.MEM_reg_write", i), MEM_reg_write, tbl[i].e_rw);
                check($sformatf("v%0d.MEM_rd_addr", i), MEM_rd_addr, tbl[i].e_rd);
                check($sformatf("v%0d.fwd_write", i), EXE_MEM_fwd_write, tbl[i].e_fwd);
                check($sformatf("v%0d.fwd_data", i), EXE_MEM_fwd_data, tbl[i].e_alu);
                check($sformatf("v%0d.dm_req", i), dm_req, tbl[i].e_req);
                check($sformatf("v%0d.dm_we", i), dm_we, tbl[i].e_we);
                check($sformatf("v%0d.mem_busy", i), mem_busy, tbl[i].e_busy);
                check($sformatf("v%0d.dm_addr", i), dm_addr, tbl[i].e_alu);
                check($sformatf("v%0d.dm_wdata", i), dm_wdata, tbl[i].e_wd);
            end
            if (model_ok) model_check(i);
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            int kind;
            rst           = ($urandom_range(0, 63) == 0);
            EXE_valid     = ($urandom_range(0, 3) != 0);
            EXE_alu_out   = $urandom;
            EXE_rs2_data  = $urandom;
            EXE_rd_addr   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            EXE_funct3    = 3'($urandom_range(0, 7));
            kind          = $urandom_range(0, 3);
            EXE_reg_write = (kind == 0) || (kind == 1) || ((kind == 3) && ($urandom_range(0, 1) == 1));
            EXE_mem_read  = (kind == 1);
            EXE_mem_write = (kind == 2);
            flush         = ($urandom_range(0, 7) == 0);
            dm_ack        = ($urandom_range(0, 2) == 0);
            #1;
            if (model_ok) model_check(100 + c);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
